// File: rtl/dct_transpose_buf_if.sv
// Row-in / column-out handshake bundle for dct_transpose_buf.
//   in_valid/in_ready/data_in     : one row per beat, lane c = element (row, c)
//   out_valid/out_ready/data_out  : one column per beat, lane r = element (r, col)
//   out_last                      : marks the final column of a block
// slave  = the transpose buffer itself; master = the upstream/downstream environment.
interface dct_transpose_buf_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DATA_DEPTH = 8
);
  logic                             in_valid;
  logic                             in_ready;
  logic [DATA_WIDTH*DATA_DEPTH-1:0] data_in;
  logic                             out_valid;
  logic                             out_ready;
  logic [DATA_WIDTH*DATA_DEPTH-1:0] data_out;
  logic                             out_last;

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, out_last
  );

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, out_last
  );
endinterface

// File: rtl/dct_transpose_buf.sv
// Ping-pong DATA_DEPTH x DATA_DEPTH transpose buffer feeding the column-DCT stage.
// Accepts one row per beat, emits one column per beat; one bank fills while the other drains.
// Ports:
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset (storage contents are not reset)
//   buf_if   : slave side of dct_transpose_buf_if (row input, column output, out_last)
module dct_transpose_buf #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DATA_DEPTH = 8
) (
  input logic                clk,
  input logic                reset_n,
  dct_transpose_buf_if.slave buf_if
);

  localparam int unsigned     CntW    = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
  localparam logic [CntW-1:0] LastIdx = CntW'(DATA_DEPTH - 1);
  localparam int unsigned     RowW    = DATA_WIDTH * DATA_DEPTH;

  // Each entry holds one full row exactly as it arrived.
  logic [RowW-1:0] mem_q [2][DATA_DEPTH];

  logic [CntW-1:0] wr_row_q, wr_row_d;
  logic [CntW-1:0] rd_col_q, rd_col_d;
  logic            wr_bank_q, wr_bank_d;
  logic            rd_bank_q, rd_bank_d;
  logic [1:0]      full_q, full_d;

  logic            in_ready;
  logic            out_valid;
  logic            wr_fire;
  logic            rd_fire;
  logic [RowW-1:0] data_out;

  assign in_ready  = !full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign wr_fire   = buf_if.in_valid && in_ready;
  assign rd_fire   = out_valid && buf_if.out_ready;

  // Completing a write and completing a read always target different banks, so the
  // set and clear below never collide.
  always_comb begin
    wr_row_d  = wr_row_q;
    wr_bank_d = wr_bank_q;
    rd_col_d  = rd_col_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    if (wr_fire) begin
      if (wr_row_q == LastIdx) begin
        wr_row_d          = '0;
        wr_bank_d         = !wr_bank_q;
        full_d[wr_bank_q] = 1'b1;
      end else begin
        wr_row_d = wr_row_q + 1'b1;
      end
    end
    if (rd_fire) begin
      if (rd_col_q == LastIdx) begin
        rd_col_d          = '0;
        rd_bank_d         = !rd_bank_q;
        full_d[rd_bank_q] = 1'b0;
      end else begin
        rd_col_d = rd_col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_row_q  <= '0;
      rd_col_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
    end else begin
      wr_row_q  <= wr_row_d;
      rd_col_q  <= rd_col_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_bank_q][wr_row_q] <= buf_if.data_in;
    end
  end

  // Column gather: lane r takes word rd_col of stored row r. Zero when nothing is valid.
  always_comb begin
    data_out = '0;
    if (out_valid) begin
      for (int r = 0; r < DATA_DEPTH; r++) begin
        data_out[r*DATA_WIDTH +: DATA_WIDTH] =
            mem_q[rd_bank_q][CntW'(r)][rd_col_q*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign buf_if.in_ready  = in_ready;
  assign buf_if.out_valid = out_valid;
  assign buf_if.data_out  = data_out;
  assign buf_if.out_last  = out_valid && (rd_col_q == LastIdx);

endmodule

// File: tb/tb_dct_transpose_buf.sv
// Directed and randomly stalled checks of dct_transpose_buf (8x8, 32-bit words).
// Block k, row r, lane c carries 256*k + 16*r + c, so column c of block k has lane r = same.
module tb_dct_transpose_buf;
  localparam int DW = 32;
  localparam int DD = 8;
  localparam int BW = DW * DD;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_pass;

  dct_transpose_buf_if #(.DATA_WIDTH(DW), .DATA_DEPTH(DD)) bus ();

  dct_transpose_buf #(.DATA_WIDTH(DW), .DATA_DEPTH(DD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .buf_if  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [BW-1:0] make_row(int blk, int row);
    logic [BW-1:0] v;
    for (int c = 0; c < DD; c++) v[c*DW +: DW] = 32'(256*blk + 16*row + c);
    return v;
  endfunction

  function automatic logic [BW-1:0] make_col(int blk, int col);
    logic [BW-1:0] v;
    for (int r = 0; r < DD; r++) v[r*DW +: DW] = 32'(256*blk + 16*r + col);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.data_out !== '0) $display("FAIL reset_data_out got %h want 0", bus.data_out); else n_pass++;
    n_checks++; if (bus.out_last !== 1'b0) $display("FAIL reset_out_last got %b want 0", bus.out_last); else n_pass++;
    reset_n = 1'b1;
    step();
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL post_reset_out_valid got %b want 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_single_block();
    bus.out_ready = 1'b1;
    for (int r = 0; r < DD; r++) begin
      bus.in_valid = 1'b1;
      bus.data_in = make_row(0, r);
      n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL single_in_ready row%0d got %b want 1", r, bus.in_ready); else n_pass++;
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL single_early_valid row%0d got %b want 0", r, bus.out_valid); else n_pass++;
      step();
    end
    bus.in_valid = 1'b0;
    bus.data_in = '0;
    for (int c = 0; c < DD; c++) begin
      n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL single_out_valid col%0d got %b want 1", c, bus.out_valid); else n_pass++;
      n_checks++; if (bus.data_out !== make_col(0, c)) $display("FAIL single_data col%0d got %h want %h", c, bus.data_out, make_col(0, c)); else n_pass++;
      n_checks++; if (bus.out_last !== (c == DD-1)) $display("FAIL single_last col%0d got %b want %b", c, bus.out_last, (c == DD-1)); else n_pass++;
      step();
    end
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL single_after_valid got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.data_out !== '0) $display("FAIL single_after_data got %h want 0", bus.data_out); else n_pass++;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL single_after_ready got %b want 1", bus.in_ready); else n_pass++;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    bit exp_v;
    int k;
    bus.out_ready = 1'b1;
    for (int t = 0; t <= 32; t++) begin
      if (t < 24) begin
        bus.in_valid = 1'b1;
        bus.data_in = make_row(t / 8, t % 8);
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL b2b_in_ready cyc%0d got %b want 1", t, bus.in_ready); else n_pass++;
      end else begin
        bus.in_valid = 1'b0;
      end
      exp_v = (t >= 8) && (t < 32);
      n_checks++; if (bus.out_valid !== exp_v) $display("FAIL b2b_out_valid cyc%0d got %b want %b", t, bus.out_valid, exp_v); else n_pass++;
      if (exp_v) begin
        k = t - 8;
        n_checks++; if (bus.data_out !== make_col(k / 8, k % 8)) $display("FAIL b2b_data cyc%0d got %h want %h", t, bus.data_out, make_col(k / 8, k % 8)); else n_pass++;
        n_checks++; if (bus.out_last !== (k % 8 == 7)) $display("FAIL b2b_last cyc%0d got %b want %b", t, bus.out_last, (k % 8 == 7)); else n_pass++;
      end
      step();
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_wrap_simultaneity();
    bus.out_ready = 1'b1;
    for (int t = 0; t < 16; t++) begin
      bus.in_valid = 1'b1;
      bus.data_in = make_row(3 + t / 8, t % 8);
      if (t == 15) begin
        // bank 1 row 7 is written while bank 0 col 7 is read at the coming edge
        n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL wrap_pre_ready got %b want 1", bus.in_ready); else n_pass++;
        n_checks++; if (bus.out_last !== 1'b1) $display("FAIL wrap_pre_last got %b want 1", bus.out_last); else n_pass++;
        n_checks++; if (bus.data_out !== make_col(3, 7)) $display("FAIL wrap_pre_data got %h want %h", bus.data_out, make_col(3, 7)); else n_pass++;
      end
      step();
    end
    bus.in_valid = 1'b0;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL wrap_post_ready got %b want 1", bus.in_ready); else n_pass++;
    for (int c = 0; c < DD; c++) begin
      n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL wrap_valid col%0d got %b want 1", c, bus.out_valid); else n_pass++;
      n_checks++; if (bus.data_out !== make_col(4, c)) $display("FAIL wrap_data col%0d got %h want %h", c, bus.data_out, make_col(4, c)); else n_pass++;
      n_checks++; if (bus.out_last !== (c == 7)) $display("FAIL wrap_last col%0d got %b want %b", c, bus.out_last, (c == 7)); else n_pass++;
      step();
    end
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL wrap_drained got %b want 0", bus.out_valid); else n_pass++;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int  sent = 0;
    int  got = 0;
    bit  acc;
    bus.out_ready = 1'b0;
    for (int t = 0; t < 20; t++) begin
      bus.in_valid = 1'b1;
      bus.data_in = make_row(sent / 8, sent % 8);
      n_checks++; if (bus.in_ready !== (t < 16)) $display("FAIL bp_in_ready cyc%0d got %b want %b", t, bus.in_ready, (t < 16)); else n_pass++;
      n_checks++; if (bus.out_valid !== (t >= 8)) $display("FAIL bp_out_valid cyc%0d got %b want %b", t, bus.out_valid, (t >= 8)); else n_pass++;
      acc = bus.in_ready;
      step();
      if (acc) sent++;
    end
    n_checks++; if (sent != 16) $display("FAIL bp_rows_accepted got %0d want 16", sent); else n_pass++;
    n_checks++; if (bus.data_out !== make_col(0, 0)) $display("FAIL bp_held_data got %h want %h", bus.data_out, make_col(0, 0)); else n_pass++;
    n_checks++; if (bus.out_last !== 1'b0) $display("FAIL bp_held_last got %b want 0", bus.out_last); else n_pass++;
    for (int t = 0; t < 80 && got < 24; t++) begin
      bus.in_valid = (sent < 24);
      bus.data_in = make_row(sent / 8, sent % 8);
      bus.out_ready = 1'b1;
      if (bus.out_valid) begin
        n_checks++; if (bus.data_out !== make_col(got / 8, got % 8)) $display("FAIL bp_data beat%0d got %h want %h", got, bus.data_out, make_col(got / 8, got % 8)); else n_pass++;
        n_checks++; if (bus.out_last !== (got % 8 == 7)) $display("FAIL bp_last beat%0d got %b want %b", got, bus.out_last, (got % 8 == 7)); else n_pass++;
        got++;
      end
      acc = bus.in_valid && bus.in_ready;
      step();
      if (acc) sent++;
    end
    n_checks++; if (got != 24) $display("FAIL bp_cols_drained got %0d want 24", got); else n_pass++;
    n_checks++; if (sent != 24) $display("FAIL bp_rows_total got %0d want 24", sent); else n_pass++;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL bp_idle_valid got %b want 0", bus.out_valid); else n_pass++;
  endtask

  task automatic test_random_stalls();
    int            sent = 0;
    int            got = 0;
    bit            acc;
    bit            prev_stall = 1'b0;
    logic          prev_last = 1'b0;
    logic [BW-1:0] prev_data = '0;
    for (int t = 0; t < 6000 && got < 400; t++) begin
      if (prev_stall) begin
        n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL rnd_stall_valid cyc%0d got %b want 1", t, bus.out_valid); else n_pass++;
        n_checks++; if (bus.data_out !== prev_data) $display("FAIL rnd_stall_data cyc%0d got %h want %h", t, bus.data_out, prev_data); else n_pass++;
        n_checks++; if (bus.out_last !== prev_last) $display("FAIL rnd_stall_last cyc%0d got %b want %b", t, bus.out_last, prev_last); else n_pass++;
      end
      bus.in_valid = (sent < 400) && ($urandom_range(1) == 1);
      bus.data_in = make_row(sent / 8, sent % 8);
      bus.out_ready = ($urandom_range(1) == 1);
      if (bus.out_valid && bus.out_ready) begin
        n_checks++; if (bus.data_out !== make_col(got / 8, got % 8)) $display("FAIL rnd_data beat%0d got %h want %h", got, bus.data_out, make_col(got / 8, got % 8)); else n_pass++;
        n_checks++; if (bus.out_last !== (got % 8 == 7)) $display("FAIL rnd_last beat%0d got %b want %b", got, bus.out_last, (got % 8 == 7)); else n_pass++;
        got++;
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_data = bus.data_out;
      prev_last = bus.out_last;
      acc = bus.in_valid && bus.in_ready;
      step();
      if (acc) sent++;
    end
    n_checks++; if (got != 400) $display("FAIL rnd_cols_total got %0d want 400", got); else n_pass++;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    for (int t = 0; t < 12; t++) begin
      bus.in_valid = 1'b1;
      bus.data_in = make_row(t / 8, t % 8);
      bus.out_ready = (t >= 8);
      step();
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    n_checks++; if (bus.in_ready !== 1'b1) $display("FAIL rstmid_in_ready got %b want 1", bus.in_ready); else n_pass++;
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rstmid_out_valid got %b want 0", bus.out_valid); else n_pass++;
    n_checks++; if (bus.data_out !== '0) $display("FAIL rstmid_data_out got %h want 0", bus.data_out); else n_pass++;
    n_checks++; if (bus.out_last !== 1'b0) $display("FAIL rstmid_out_last got %b want 0", bus.out_last); else n_pass++;
    #1 reset_n = 1'b1;
    step();
    bus.out_ready = 1'b1;
    for (int r = 0; r < DD; r++) begin
      bus.in_valid = 1'b1;
      bus.data_in = make_row(9, r);
      n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rstmid_fill_valid row%0d got %b want 0", r, bus.out_valid); else n_pass++;
      step();
    end
    bus.in_valid = 1'b0;
    for (int c = 0; c < DD; c++) begin
      n_checks++; if (bus.out_valid !== 1'b1) $display("FAIL rstmid_valid col%0d got %b want 1", c, bus.out_valid); else n_pass++;
      n_checks++; if (bus.data_out !== make_col(9, c)) $display("FAIL rstmid_data col%0d got %h want %h", c, bus.data_out, make_col(9, c)); else n_pass++;
      step();
    end
    n_checks++; if (bus.out_valid !== 1'b0) $display("FAIL rstmid_end_valid got %b want 0", bus.out_valid); else n_pass++;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_pass = 0;
    test_reset();
    test_single_block();
    test_back_to_back();
    test_wrap_simultaneity();
    test_backpressure();
    test_random_stalls();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dct_transpose_buf.md
# dct_transpose_buf

Ping-pong 8x8 transpose buffer placed directly upstream of the column-DCT stage (`dct_2d_col`). It accepts one row of `DATA_DEPTH` words per beat and emits one column of `DATA_DEPTH` words per beat, so the column stage sees data in transposed order. It is format-agnostic and performs no arithmetic. Two banks allow one block to fill while the previous block drains, giving sustained one-beat-per-cycle throughput.

## Interface
- `DATA_WIDTH`, 32, width of one word in bits.
- `DATA_DEPTH`, 8, words per row/column, and rows/columns per block; must be ≥ 2.
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  row beat on `data_in` is valid.
- `in_ready`  out  1  buffer can accept a row this cycle.
- `data_in`  in  `DATA_WIDTH*DATA_DEPTH`  one row; lane c = `[c*DATA_WIDTH +: DATA_WIDTH]` = element (row, c).
- `out_valid`  out  1  column beat on `data_out` is valid.
- `out_ready`  in  1  downstream accepts a column this cycle.
- `data_out`  out  `DATA_WIDTH*DATA_DEPTH`  one column; lane r = element (r, col).
- `out_last`  out  1  high with the final column (col = `DATA_DEPTH-1`) of a block.

## Operation
- Storage: 2 banks × `DATA_DEPTH`×`DATA_DEPTH` words. Counters: `wr_row` and `rd_col`, each `$clog2(DATA_DEPTH)` bits. Pointers: `wr_bank` and `rd_bank`, 1 bit each. Per-bank `full` flag.
- Bank states: EMPTY (`full`=0) → FILLING (implicit, when `wr_bank` points at it and `wr_row` > 0) → FULL (`full`=1) → DRAINING (implicit, when `rd_bank` points at it and `rd_col` > 0) → EMPTY.
- Write handshake: a row is accepted when `in_valid && in_ready`.
  - It is stored at `bank[wr_bank]` row `wr_row`, and `wr_row` increments.
  - On the acceptance with `wr_row == DATA_DEPTH-1`: set `full[wr_bank]`, wrap `wr_row` to 0, toggle `wr_bank`.
- `in_ready = !full[wr_bank]`.
- Read handshake: a column is transferred when `out_valid && out_ready`, and `rd_col` increments.
  - On the transfer with `rd_col == DATA_DEPTH-1`: clear `full[rd_bank]`, wrap `rd_col` to 0, toggle `rd_bank`.
- `out_valid = full[rd_bank]`.
- `data_out` lane r = `bank[rd_bank][r][rd_col]` when `out_valid`=1; all zeros when `out_valid`=0.
- `out_last = out_valid && (rd_col == DATA_DEPTH-1)`.
- Held outputs: `data_out` and `out_last` remain stable while `out_valid && !out_ready`.
- Simultaneous events:
  - A write completing one bank and a read completing the other bank in the same cycle both take effect.
  - Set and clear never target the same bank in the same cycle, because `wr_bank != rd_bank` whenever both are completing.
- `in_valid` is ignored when `in_ready`=0. Nothing is written and no counter moves.
- Blocks leave in the order they entered. No block is dropped or duplicated.

## Timing
- Reset (async assert, sync-safe deassert):
  - `wr_row`, `rd_col`, `wr_bank`, `rd_bank` = 0; both `full` = 0.
  - `in_ready`=1, `out_valid`=0, `data_out`=0, `out_last`=0.
  - Storage contents are not reset.
- Reset mid-block discards all partially written and undrained data. The first row after reset is row 0 of bank 0.
- Latency: the row-`DATA_DEPTH-1` handshake in cycle N gives `out_valid`=1 in cycle N+1, presenting column 0.
- Throughput with `in_valid`=`out_ready`=1 continuously: `in_ready` stays 1, and `out_valid` stays 1 from the first block's completion onward, with no bubbles.
- Freed bank: it becomes writable the cycle after its last column transfers.
- With `out_ready` held 0:
  - The first block fills bank 0 and the second fills bank 1.
  - `in_ready` drops the cycle after row 7 of the second block is accepted.

## Test plan
- **Single block.** Drive 8 rows with row r lane c = `16*r+c`, `out_ready`=1.
  - `out_valid` rises the cycle after row 7.
  - Column c lane r = `16*r+c`.
  - `out_last` is high only on col 7.
  - `out_valid` returns to 0 afterwards.
- **Back-to-back.** Send 3 blocks with continuous `in_valid`; `out_ready`=1; block k value = `256*k+16*r+c`.
  - 24 consecutive output beats on cycles 8–31.
  - `in_ready` never 0; correct transposes, in order.
- **Backpressure.** Hold `out_ready`=0 and push 20 rows.
  - `in_ready`=0 from cycle 16; rows 16–19 are held off.
  - After raising `out_ready`: block 0, then block 1, then block 2 is accepted and drains correctly.
- **Random stalls.** Randomly gate `in_valid` and `out_ready` (50%) over 50 blocks.
  - Output matches a reference transpose model.
  - `data_out` is stable during every stalled `out_valid` cycle.
- **Reset mid-operation.** Assert `reset_n`=0 after row 3 of block 1 while block 0 is half-drained.
  - All outputs show reset values immediately.
  - A fresh block afterwards emerges transposed, with no stale data.
- **Wrap and simultaneity.** Check the cycle in which bank 1's row 7 is written while bank 0's col 7 is read.
  - Both flags update correctly.
  - The next cycle has `out_valid`=1 with bank 1 col 0, and `in_ready`=1 into bank 0.
